spi_flash_apb_master: RTL
=========================

// Module: spi_flash_apb_master
// PURPOSE
// Upstream driver for the SPI-flash APB slave port. Accepts single read/write
// requests on a valid/ready interface, runs one APB transfer (SETUP, ACCESS,
// wait for pready) and returns data/status on a valid/ready response channel.
// Bounds every transfer with a pready timeout so a stalled flash cannot hang
// the requester (boot loader / CPU bus adapter).
// PARAMETERS
// TIMEOUT_CYCLES  1023  ACCESS cycles without pready before abort (>=1)
// CNT_W           10    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
// clk          in   1   single clock; also drives APB pclk
// rst          in   1   synchronous reset, active-high
// req_valid    in   1   request present
// req_ready    out  1   request accepted when req_valid&req_ready
// req_write    in   1   1=APB write, 0=APB read
// req_addr     in   32  byte address; bits[1:0] ignored
// req_wdata    in   32  write data
// rsp_valid    out  1   response present
// rsp_ready    in   1   response consumed when rsp_valid&rsp_ready
// rsp_rdata    out  32  read data (0 for writes and timeouts)
// rsp_err      out  1   prslverr sampled high, or timeout
// rsp_timeout  out  1   transfer aborted by timeout
// busy         out  1   high in any state but IDLE
// paddr        out  32  APB address, {req_addr[31:2],2'b00}
// psel         out  1   APB select
// penable      out  1   APB enable
// pwrite       out  1   APB direction
// pwdata       out  32  APB write data
// prdata       in   32  APB read data
// prslverr     in   1   APB slave error
// pready       in   1   APB ready
// BEHAVIOUR
// - All outputs registered. Reset: state=IDLE, req_ready=1, rsp_valid=0,
//   psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_rdata=0, rsp_err=0,
//   rsp_timeout=0, busy=0, counter=0.
// - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
// - IDLE: req_ready=1. On accept: latch paddr/pwrite/pwdata, req_ready<=0,
//   psel<=1, penable<=0, go SETUP. No accept outside IDLE.
// - SETUP: exactly one cycle; penable<=1, counter<=0, go ACCESS.
// - ACCESS: psel=penable=1; paddr/pwrite/pwdata stable. Each cycle pready=0:
//   counter+1. pready=1 sampled: rsp_rdata<=pwrite?0:prdata,
//   rsp_err<=prslverr, rsp_timeout<=0, psel<=0, penable<=0, rsp_valid<=1,
//   go RESP. pready wins if it rises on the cycle the count expires.
// - Timeout: pready=0 with counter==TIMEOUT_CYCLES-1 -> psel<=0, penable<=0,
//   rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0, go RESP (deliberate APB abort).
// - RESP: rsp_valid held, payload stable until rsp_ready; then rsp_valid<=0,
//   req_ready<=1, go IDLE. rsp_ready high on entry -> IDLE next cycle.
// - Latency: accept at edge N; psel rises N+1, penable N+2; pready at N+2
//   gives rsp_valid at N+3. Minimum 4 cycles accept-to-accept.
// - Reset mid-transfer: next edge forces reset values, psel/penable drop
//   immediately, pending response discarded.
// - prdata/prslverr ignored outside ACCESS; pready outside ACCESS ignored.
// TESTING
// - Read, zero-wait: req addr 0x0000_0008, pready=1 at first ACCESS,
//   prdata=0xA5A5_1234 -> psel 2 cycles, rsp_valid 3 cycles after accept,
//   rsp_rdata=0xA5A5_1234, rsp_err=0.
// - Write, 3 wait states: addr 0x13, wdata 0xDEAD_BEEF -> paddr=0x10, pwrite=1,
//   penable high 4 cycles, rsp_rdata=0, rsp_err=0.
// - Slave error: read with prslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
// - Timeout (TIMEOUT_CYCLES=4): pready never asserted -> penable high exactly
//   4 cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
// - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/payload stable,
//   req_ready=0, no new psel; req_valid held is accepted after release.
// - Reset in ACCESS: rst=1 for one cycle -> psel=penable=rsp_valid=0,
//   req_ready=1 next edge; a following read completes normally.

Source files
------------

// File: rtl/spi_flash_apb_master_if.sv
// Request/response channel plus APB bus between the requester, the master and the flash slave port.
// The "master" modport is the APB master's view; "slave" is the requester and flash side.
interface spi_flash_apb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        prslverr;
  logic        pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  prdata, prslverr, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output prdata, prslverr, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/spi_flash_apb_master.sv
// Single-outstanding APB master for the SPI-flash slave port, with a pready timeout
// so that a stalled flash always produces an error response instead of a hang.
module spi_flash_apb_master #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  spi_flash_apb_master_if.master       bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Every output is a flop; the FSM writes them directly so nothing combinational reaches the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bus.req_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.busy        <= 1'b0;
      bus.paddr       <= '0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.pwdata      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            bus.paddr     <= {bus.req_addr[31:2], 2'b00};
            bus.pwrite    <= bus.req_write;
            bus.pwdata    <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            bus.psel      <= 1'b1;
            bus.penable   <= 1'b0;
            bus.busy      <= 1'b1;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          cnt_reg     <= '0;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a late pready on the expiry cycle still completes normally.
          if (bus.pready) begin
            bus.rsp_rdata   <= bus.pwrite ? 32'h0 : bus.prdata;
            bus.rsp_err     <= bus.prslverr;
            bus.rsp_timeout <= 1'b0;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state_reg       <= RESP;
          end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state_reg       <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
